// File: rtl/eth_traffic_chk.sv
// Frame checker for one eth_traffic_gen stream port: validates header, sequence,
// length and incrementing payload, and keeps saturating good/bad/byte statistics.
module eth_traffic_chk #(
  parameter int unsigned C_AXIS_TDATA_WIDTH = 32,
  parameter int unsigned C_CNT_WIDTH        = 32,
  parameter int unsigned C_MAX_LEN          = 1518
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  input  logic [C_AXIS_TDATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [C_AXIS_TDATA_WIDTH/8-1:0] s_axis_tkeep,
  input  logic                            s_axis_tvalid,
  output logic                            s_axis_tready,
  input  logic                            s_axis_tlast,
  input  logic                            enable,
  input  logic                            clear,
  output logic [C_CNT_WIDTH-1:0]          good_frame_cnt,
  output logic [C_CNT_WIDTH-1:0]          bad_frame_cnt,
  output logic [C_CNT_WIDTH-1:0]          byte_cnt,
  output logic [2:0]                      last_err,
  output logic                            err_pulse
);

  localparam int unsigned KW = C_AXIS_TDATA_WIDTH / 8;
  localparam int unsigned NW = $clog2(KW + 1);
  localparam int unsigned SW = C_CNT_WIDTH + 1;

  localparam logic [2:0] ERR_NONE    = 3'd0;
  localparam logic [2:0] ERR_SEQ     = 3'd1;
  localparam logic [2:0] ERR_PATTERN = 3'd2;
  localparam logic [2:0] ERR_LEN     = 3'd3;
  localparam logic [2:0] ERR_SHORT   = 3'd4;
  localparam logic [2:0] ERR_LONG    = 3'd5;
  localparam logic [2:0] ERR_KEEP    = 3'd6;

  typedef enum logic [1:0] {ST_IDLE, ST_PAYLOAD, ST_DISCARD} state_e;

  // Keep the lowest non-zero error code of a frame.
  function automatic logic [2:0] merge_err(input logic [2:0] a, input logic [2:0] b);
    if (a == ERR_NONE) return b;
    if (b == ERR_NONE || a < b) return a;
    return b;
  endfunction

  state_e                 state_q;
  logic [15:0]            rem_q, len_q, exp_seq_q;
  logic [7:0]             pat_q;
  logic [2:0]             ferr_q;
  logic                   pend_good_q, pend_bad_q;
  logic [2:0]             pend_err_q;
  logic [15:0]            pend_len_q;
  logic [C_CNT_WIDTH-1:0] good_q, bad_q, byte_q;
  logic [2:0]             last_err_q;
  logic                   err_pulse_q;

  logic                   acc_c, len_bad_c, keep_full_c, keep_contig_c, mism_c, over_c;
  logic [15:0]            hdr_len_c, hdr_seq_c, rem_d;
  logic [7:0]             pat_d;
  logic [NW-1:0]          n_c;
  logic [2:0]             hdr_err_c, pay_err_c;
  logic [SW-1:0]          byte_sum_c;

  assign s_axis_tready = enable & ~clear & ~ARESET;
  assign acc_c         = s_axis_tvalid & s_axis_tready;
  assign hdr_len_c     = s_axis_tdata[15:0];
  assign hdr_seq_c     = s_axis_tdata[31:16];
  assign len_bad_c     = (hdr_len_c == 16'd0) || (hdr_len_c > 16'(C_MAX_LEN));
  assign keep_full_c   = &s_axis_tkeep;
  assign keep_contig_c = (s_axis_tkeep != '0) &&
                         ((s_axis_tkeep & (s_axis_tkeep + KW'(1))) == '0);
  assign byte_sum_c    = {1'b0, byte_q} + SW'(pend_len_q);

  // Per-lane payload compare and byte accounting for the current beat.
  always_comb begin
    n_c    = '0;
    mism_c = 1'b0;
    for (int i = 0; i < KW; i++) begin
      if (s_axis_tkeep[i]) begin
        n_c = n_c + NW'(1);
        if (s_axis_tdata[8*i +: 8] != pat_q + 8'(i)) mism_c = 1'b1;
      end
    end
    over_c = 16'(n_c) > rem_q;
    rem_d  = over_c ? 16'd0 : rem_q - 16'(n_c);
    pat_d  = pat_q + 8'(n_c);
  end

  // Error code accumulated by a header beat and by a payload beat.
  always_comb begin
    hdr_err_c = ERR_NONE;
    if (hdr_seq_c != exp_seq_q) hdr_err_c = merge_err(hdr_err_c, ERR_SEQ);
    if (!keep_full_c)           hdr_err_c = merge_err(hdr_err_c, ERR_KEEP);
    if (s_axis_tlast)           hdr_err_c = merge_err(hdr_err_c, ERR_SHORT);
    else if (len_bad_c)         hdr_err_c = merge_err(hdr_err_c, ERR_LEN);

    pay_err_c = ferr_q;
    if (mism_c) pay_err_c = merge_err(pay_err_c, ERR_PATTERN);
    if (s_axis_tlast ? !keep_contig_c : !keep_full_c)
      pay_err_c = merge_err(pay_err_c, ERR_KEEP);
    if (s_axis_tlast) begin
      if (rem_d != 16'd0) pay_err_c = merge_err(pay_err_c, ERR_SHORT);
      else if (over_c)    pay_err_c = merge_err(pay_err_c, ERR_LONG);
    end else if (rem_d == 16'd0) begin
      pay_err_c = merge_err(pay_err_c, ERR_LONG);
    end
  end

  // Frame FSM, one-cycle pending verdict stage and saturating statistics.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q     <= ST_IDLE;
      rem_q       <= '0;
      len_q       <= '0;
      exp_seq_q   <= '0;
      pat_q       <= '0;
      ferr_q      <= ERR_NONE;
      pend_good_q <= 1'b0;
      pend_bad_q  <= 1'b0;
      pend_err_q  <= ERR_NONE;
      pend_len_q  <= '0;
      good_q      <= '0;
      bad_q       <= '0;
      byte_q      <= '0;
      last_err_q  <= ERR_NONE;
      err_pulse_q <= 1'b0;
    end else if (clear) begin
      state_q     <= ST_IDLE;
      exp_seq_q   <= '0;
      ferr_q      <= ERR_NONE;
      pend_good_q <= 1'b0;
      pend_bad_q  <= 1'b0;
      good_q      <= '0;
      bad_q       <= '0;
      byte_q      <= '0;
      last_err_q  <= ERR_NONE;
      err_pulse_q <= 1'b0;
    end else begin
      pend_good_q <= 1'b0;
      pend_bad_q  <= 1'b0;
      pend_len_q  <= len_q;
      if (acc_c) begin
        case (state_q)
          ST_IDLE: begin
            exp_seq_q <= hdr_seq_c + 16'd1;
            ferr_q    <= hdr_err_c;
            len_q     <= hdr_len_c;
            rem_q     <= hdr_len_c;
            pat_q     <= hdr_seq_c[7:0];
            if (s_axis_tlast) begin
              pend_bad_q <= 1'b1;
              pend_err_q <= hdr_err_c;
            end else if (len_bad_c) begin
              state_q <= ST_DISCARD;
            end else begin
              state_q <= ST_PAYLOAD;
            end
          end
          ST_PAYLOAD: begin
            rem_q  <= rem_d;
            pat_q  <= pat_d;
            ferr_q <= pay_err_c;
            if (s_axis_tlast) begin
              pend_good_q <= (pay_err_c == ERR_NONE);
              pend_bad_q  <= (pay_err_c != ERR_NONE);
              pend_err_q  <= pay_err_c;
              state_q     <= ST_IDLE;
            end else if (rem_d == 16'd0) begin
              state_q <= ST_DISCARD;
            end
          end
          ST_DISCARD: begin
            if (s_axis_tlast) begin
              pend_bad_q <= 1'b1;
              pend_err_q <= ferr_q;
              state_q    <= ST_IDLE;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end

      err_pulse_q <= pend_bad_q;
      if (pend_good_q) begin
        if (good_q != '1) good_q <= good_q + C_CNT_WIDTH'(1);
        byte_q <= byte_sum_c[C_CNT_WIDTH] ? '1 : byte_sum_c[C_CNT_WIDTH-1:0];
      end
      if (pend_bad_q) begin
        if (bad_q != '1) bad_q <= bad_q + C_CNT_WIDTH'(1);
        last_err_q <= pend_err_q;
      end
    end
  end

  assign good_frame_cnt = good_q;
  assign bad_frame_cnt  = bad_q;
  assign byte_cnt       = byte_q;
  assign last_err       = last_err_q;
  assign err_pulse      = err_pulse_q;

endmodule
